// File: rtl/mmu_pkg.sv
// rtl/mmu_pkg.sv - shared constants, state encoding and TLB entry type for mmu_tlb
package mmu_pkg;

   localparam int PAGE_BITS = 12;
   localparam int VPN_BITS  = 32 - PAGE_BITS;
   localparam int PPN_BITS  = 32 - PAGE_BITS;

   // PTE layout: [31:12] PPN, [1] writable, [0] valid
   localparam int PTE_V = 0;
   localparam int PTE_W = 1;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LOOKUP    = 3'd1,
      S_WALK_REQ  = 3'd2,
      S_WALK_WAIT = 3'd3,
      S_ISSUE     = 3'd4,
      S_WAIT_CC   = 3'd5,
      S_CC_DONE   = 3'd6,
      S_RESP      = 3'd7
   } state_t;

   typedef struct packed {
      logic                valid;
      logic [VPN_BITS-1:0] vpn;
      logic [PPN_BITS-1:0] ppn;
      logic                w;
   } tlb_entry;

endpackage

// File: rtl/tlb_array.sv
// rtl/tlb_array.sv - fully-associative TLB storage with CAM lookup, round-robin fill and flush
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               clear every valid bit this cycle (beats a same-cycle fill)
//   lookup_vpn          VPN to compare against all valid entries
//   hit, hit_ppn, hit_w lookup result; lowest matching index wins
//   fill_en             write {fill_vpn, fill_ppn, fill_w} at the round-robin pointer
module tlb_array
   import mmu_pkg::*;
#(
   parameter int ENTRIES = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   input  logic [VPN_BITS-1:0] lookup_vpn,
   output logic                hit,
   output logic [PPN_BITS-1:0] hit_ppn,
   output logic                hit_w,
   input  logic                fill_en,
   input  logic [VPN_BITS-1:0] fill_vpn,
   input  logic [PPN_BITS-1:0] fill_ppn,
   input  logic                fill_w
);

   localparam int IDX_BITS = $clog2(ENTRIES);

   tlb_entry            entries [ENTRIES];
   logic [IDX_BITS-1:0] ptr;

   // Scan from the top down so the lowest matching index is the one left standing.
   always_comb begin
      hit     = 1'b0;
      hit_ppn = '0;
      hit_w   = 1'b0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (entries[i].valid && (entries[i].vpn == lookup_vpn)) begin
            hit     = 1'b1;
            hit_ppn = entries[i].ppn;
            hit_w   = entries[i].w;
         end
      end
   end

   // The pointer advances on every fill even when a flush drops the entry write;
   // flush never rewinds it. ENTRIES is a power of two, so the add wraps for free.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            entries[i] <= '0;
         end
         ptr <= '0;
      end else begin
         if (fill_en) begin
            ptr <= ptr + IDX_BITS'(1);
         end
         if (flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
               entries[i].valid <= 1'b0;
            end
         end else if (fill_en) begin
            entries[ptr] <= '{valid: 1'b1, vpn: fill_vpn, ppn: fill_ppn, w: fill_w};
         end
      end
   end

endmodule

// File: rtl/mmu_tlb.sv
// rtl/mmu_tlb.sv - VA to PA translation stage with 8-entry TLB and page-table walker
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   cpu_req_*, cpu_vaddr, cpu_wdata    CPU load/store request (accepted when ready)
//   cpu_resp_valid/rdata/page_fault    one-cycle completion with load data or fault
//   ptbr, tlb_flush                    page-table base, TLB invalidate-all
//   pt_req/pt_addr/pt_rdata/pt_ready   page-table word-read port
//   cc_*                               cache controller strobes, address, data, stall
module mmu_tlb #(
   parameter int ENTRIES   = 8,
   parameter int PAGE_BITS = 12
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cpu_req_valid,
   input  logic        cpu_req_write,
   input  logic [31:0] cpu_vaddr,
   input  logic [31:0] cpu_wdata,
   output logic        cpu_req_ready,
   output logic        cpu_resp_valid,
   output logic [31:0] cpu_rdata,
   output logic        cpu_page_fault,
   input  logic [31:0] ptbr,
   input  logic        tlb_flush,
   output logic        pt_req,
   output logic [31:0] pt_addr,
   input  logic [31:0] pt_rdata,
   input  logic        pt_ready,
   output logic [31:0] cc_phy_addr,
   output logic [31:0] cc_data_out,
   output logic        cc_read_mem,
   output logic        cc_write_mem,
   input  logic [31:0] cc_data_in,
   input  logic        cc_ready_stall
);

   import mmu_pkg::*;

   state_t              state;
   logic [31:0]         vaddr_q;
   logic [31:0]         wdata_q;
   logic                write_q;
   logic                wait_first;

   logic                hit;
   logic [PPN_BITS-1:0] hit_ppn;
   logic                hit_w;
   logic                fill_en;
   logic [VPN_BITS-1:0] vpn;

   // PTE bits between the flags and the PPN carry nothing.
   logic                unused_pte_bits;
   assign unused_pte_bits = ^pt_rdata[PAGE_BITS-1:PTE_W+1];

   assign vpn     = vaddr_q[31:PAGE_BITS];
   assign fill_en = (state == S_WALK_WAIT) && pt_ready && pt_rdata[PTE_V];

   tlb_array #(
      .ENTRIES (ENTRIES)
   ) u_tlb (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (tlb_flush),
      .lookup_vpn (vpn),
      .hit        (hit),
      .hit_ppn    (hit_ppn),
      .hit_w      (hit_w),
      .fill_en    (fill_en),
      .fill_vpn   (vpn),
      .fill_ppn   (pt_rdata[31:PAGE_BITS]),
      .fill_w     (pt_rdata[PTE_W])
   );

   // The strobe has to land in the same cycle the cache reports idle, so it is
   // decoded from state and stall rather than registered.
   assign cc_read_mem  = (state == S_ISSUE) && !cc_ready_stall && !write_q;
   assign cc_write_mem = (state == S_ISSUE) && !cc_ready_stall &&  write_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         vaddr_q        <= '0;
         wdata_q        <= '0;
         write_q        <= 1'b0;
         wait_first     <= 1'b0;
         cpu_req_ready  <= 1'b0;
         cpu_resp_valid <= 1'b0;
         cpu_rdata      <= '0;
         cpu_page_fault <= 1'b0;
         pt_req         <= 1'b0;
         pt_addr        <= '0;
         cc_phy_addr    <= '0;
         cc_data_out    <= '0;
      end else begin
         pt_req         <= 1'b0;
         cpu_resp_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               cpu_req_ready <= 1'b1;
               if (cpu_req_valid && cpu_req_ready) begin
                  vaddr_q       <= cpu_vaddr;
                  wdata_q       <= cpu_wdata;
                  write_q       <= cpu_req_write;
                  cpu_req_ready <= 1'b0;
                  state         <= S_LOOKUP;
               end
            end
            S_LOOKUP: begin
               if (hit) begin
                  if (write_q && !hit_w) begin
                     cpu_page_fault <= 1'b1;
                     cpu_resp_valid <= 1'b1;
                     state          <= S_RESP;
                  end else begin
                     cc_phy_addr <= {hit_ppn, vaddr_q[PAGE_BITS-1:0]};
                     cc_data_out <= wdata_q;
                     state       <= S_ISSUE;
                  end
               end else begin
                  pt_req  <= 1'b1;
                  pt_addr <= (ptbr & 32'hFFFF_F000) + 32'({vpn, 2'b00});
                  state   <= S_WALK_REQ;
               end
            end
            S_WALK_REQ: begin
               state <= S_WALK_WAIT;
            end
            S_WALK_WAIT: begin
               if (pt_ready) begin
                  if (!pt_rdata[PTE_V] || (write_q && !pt_rdata[PTE_W])) begin
                     cpu_page_fault <= 1'b1;
                     cpu_resp_valid <= 1'b1;
                     state          <= S_RESP;
                  end else begin
                     cc_phy_addr <= {pt_rdata[31:PAGE_BITS], vaddr_q[PAGE_BITS-1:0]};
                     cc_data_out <= wdata_q;
                     state       <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               if (!cc_ready_stall) begin
                  wait_first <= 1'b1;
                  state      <= S_WAIT_CC;
               end
            end
            S_WAIT_CC: begin
               // The cache raises stall only after it registers the strobe, so the
               // first cycle here says nothing about completion.
               if (wait_first) begin
                  wait_first <= 1'b0;
               end else if (!cc_ready_stall) begin
                  state <= S_CC_DONE;
               end
            end
            S_CC_DONE: begin
               if (!write_q) begin
                  cpu_rdata <= cc_data_in;
               end
               cpu_resp_valid <= 1'b1;
               state          <= S_RESP;
            end
            S_RESP: begin
               cpu_rdata      <= '0;
               cpu_page_fault <= 1'b0;
               cpu_req_ready  <= 1'b1;
               state          <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mmu_tlb.sv
// tb/tb_mmu_tlb.sv - self-checking bench for mmu_tlb
module tb_mmu_tlb;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cpu_req_valid, cpu_req_write;
   logic [31:0] cpu_vaddr, cpu_wdata;
   logic        cpu_req_ready, cpu_resp_valid, cpu_page_fault;
   logic [31:0] cpu_rdata;
   logic [31:0] ptbr;
   logic        tlb_flush;
   logic        pt_req, pt_ready;
   logic [31:0] pt_addr, pt_rdata;
   logic [31:0] cc_phy_addr, cc_data_out, cc_data_in;
   logic        cc_read_mem, cc_write_mem, cc_ready_stall;

   mmu_tlb #(.ENTRIES(8), .PAGE_BITS(12)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req_valid(cpu_req_valid), .cpu_req_write(cpu_req_write),
      .cpu_vaddr(cpu_vaddr), .cpu_wdata(cpu_wdata), .cpu_req_ready(cpu_req_ready),
      .cpu_resp_valid(cpu_resp_valid), .cpu_rdata(cpu_rdata), .cpu_page_fault(cpu_page_fault),
      .ptbr(ptbr), .tlb_flush(tlb_flush),
      .pt_req(pt_req), .pt_addr(pt_addr), .pt_rdata(pt_rdata), .pt_ready(pt_ready),
      .cc_phy_addr(cc_phy_addr), .cc_data_out(cc_data_out),
      .cc_read_mem(cc_read_mem), .cc_write_mem(cc_write_mem),
      .cc_data_in(cc_data_in), .cc_ready_stall(cc_ready_stall)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Environment: page table keyed by VPN, backing memory keyed by PA.
   logic [31:0] pte_tab [logic [19:0]];
   logic [31:0] mem [logic [31:0]];

   function automatic logic [31:0] mem_rd(input logic [31:0] pa);
      if (mem.exists(pa)) return mem[pa];
      return pa ^ 32'hDEAD_0000;
   endfunction

   // Reference TLB: eight slots, a replacement pointer that advances on each fill.
   bit          m_valid [8];
   logic [19:0] m_vpn   [8];
   logic [19:0] m_ppn   [8];
   bit          m_w     [8];
   int          m_ptr = 0;

   // Expectations for the request in flight and what the monitor observed.
   bit          req_active = 0;
   bit          exp_walk, exp_fault, exp_write;
   logic [31:0] exp_pt_addr, exp_pa, exp_rdata, exp_wdata;
   int          n_pt_req, n_strobe, acc_cyc, strobe_cyc;
   bit          resp_seen, flush_arm = 0;
   logic [31:0] last_pt_addr, last_pa, last_rdata;
   logic        last_fault;

   task automatic predict(input bit w, input logic [31:0] va, input logic [31:0] wd, input bit fl);
      logic [19:0] vpn;
      logic [19:0] ppn;
      logic [31:0] pte;
      bit          wr;
      int          idx;
      vpn = va[31:12];
      idx = -1;
      for (int i = 0; i < 8; i++)
         if (idx < 0 && m_valid[i] && m_vpn[i] == vpn) idx = i;
      exp_walk = (idx < 0);
      exp_fault = 0;
      exp_pt_addr = 32'h0;
      ppn = 20'h0;
      wr = 0;
      if (idx >= 0) begin
         ppn = m_ppn[idx];
         wr  = m_w[idx];
      end else begin
         exp_pt_addr = (ptbr & 32'hFFFF_F000) + {10'b0, vpn, 2'b00};
         pte = pte_tab.exists(vpn) ? pte_tab[vpn] : 32'h0;
         if (!pte[0]) begin
            exp_fault = 1;
         end else begin
            ppn = pte[31:12];
            wr  = pte[1];
            m_valid[m_ptr] = 1;
            m_vpn[m_ptr]   = vpn;
            m_ppn[m_ptr]   = ppn;
            m_w[m_ptr]     = wr;
            m_ptr = (m_ptr + 1) % 8;
         end
         if (fl)
            for (int i = 0; i < 8; i++) m_valid[i] = 0;
      end
      if (!exp_fault && w && !wr) exp_fault = 1;
      exp_pa    = {ppn, va[11:0]};
      exp_write = w;
      exp_wdata = wd;
      exp_rdata = (exp_fault || w) ? 32'h0 : mem_rd(exp_pa);
   endtask

   task automatic run_req(input bit w, input logic [31:0] va, input logic [31:0] wd, input bit fl);
      bit accepted;
      predict(w, va, wd, fl);
      n_pt_req = 0;
      n_strobe = 0;
      resp_seen = 0;
      req_active = 1;
      flush_arm = fl;
      accepted = 0;
      cpu_req_valid = 1;
      cpu_req_write = w;
      cpu_vaddr = va;
      cpu_wdata = wd;
      for (int k = 0; k < 100 && !accepted; k++) begin
         @(negedge clk);
         if (cpu_req_ready) begin
            acc_cyc = cyc;
            accepted = 1;
         end
      end
      @(posedge clk); #1;
      cpu_req_valid = 0;
      cpu_req_write = ~w;
      cpu_vaddr = 32'hFFFF_FFFF;
      cpu_wdata = 32'h0BAD_0BAD;
      if (!accepted) check("accept_timeout", 0, 1);
      for (int k = 0; k < 300 && !resp_seen; k++) @(posedge clk);
      check("resp_seen", 32'(resp_seen), 1);
      @(posedge clk); #1;
      req_active = 0;
   endtask

   // Compare process.
   always @(negedge clk) begin
      if (rst_n) begin
         if (!req_active)
            check("idle_outputs", {28'h0, pt_req, cc_read_mem, cc_write_mem, cpu_resp_valid}, 0);
         if (pt_req) begin
            n_pt_req++;
            last_pt_addr = pt_addr;
            check("pt_addr", pt_addr, exp_pt_addr);
         end
         if (cc_read_mem || cc_write_mem) begin
            n_strobe++;
            strobe_cyc = cyc;
            last_pa = cc_phy_addr;
            check("cc_phy_addr", cc_phy_addr, exp_pa);
            check("cc_write_mem", 32'(cc_write_mem), 32'(exp_write));
            check("cc_read_mem", 32'(cc_read_mem), 32'(!exp_write));
            if (exp_write) check("cc_data_out", cc_data_out, exp_wdata);
         end
         if (cpu_resp_valid) begin
            last_rdata = cpu_rdata;
            last_fault = cpu_page_fault;
            check("cpu_page_fault", 32'(cpu_page_fault), 32'(exp_fault));
            check("cpu_rdata", cpu_rdata, exp_rdata);
            check("pt_req_count", n_pt_req, 32'(exp_walk));
            check("strobe_count", n_strobe, exp_fault ? 0 : 1);
            if (!exp_walk && !exp_fault) check("hit_latency", strobe_cyc - acc_cyc, 2);
            resp_seen = 1;
         end
      end
   end

   // Cache controller: busy for three cycles after the cycle following a strobe.
   initial begin
      logic s_rd, s_wr;
      logic [31:0] a, d;
      int cnt;
      cnt = 0;
      cc_ready_stall = 0;
      cc_data_in = 0;
      forever begin
         @(negedge clk);
         s_rd = cc_read_mem;
         s_wr = cc_write_mem;
         a = cc_phy_addr;
         d = cc_data_out;
         @(posedge clk); #1;
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) cc_ready_stall = 0;
         end else if (s_rd || s_wr) begin
            cc_ready_stall = 1;
            cnt = 3;
            if (s_wr) mem[a] = d;
            else cc_data_in = mem_rd(a);
         end
      end
   end

   // Page-table port: answers two cycles after the request; optional flush alongside.
   initial begin
      logic [31:0] a;
      logic [19:0] v;
      pt_ready = 0;
      pt_rdata = 0;
      tlb_flush = 0;
      forever begin
         @(posedge clk); #1;
         pt_ready = 0;
         tlb_flush = 0;
         if (rst_n && pt_req) begin
            a = pt_addr;
            @(posedge clk); #1;
            @(posedge clk); #1;
            v = 20'((a - (ptbr & 32'hFFFF_F000)) >> 2);
            pt_rdata = pte_tab.exists(v) ? pte_tab[v] : 32'h0;
            pt_ready = 1;
            tlb_flush = flush_arm;
            flush_arm = 0;
         end
      end
   end

   initial begin
      cpu_req_valid = 0;
      cpu_req_write = 0;
      cpu_vaddr = 0;
      cpu_wdata = 0;
      ptbr = 32'h0010_0ABC;
      for (int i = 0; i < 8; i++) m_valid[i] = 0;
      pte_tab[20'h00005] = 32'h0003_7003;
      pte_tab[20'h00042] = 32'h0004_2001;
      pte_tab[20'h00077] = 32'h0000_0000;
      pte_tab[20'h00009] = 32'h0009_9003;
      pte_tab[20'hFFFFF] = 32'h0000_1003;
      for (int v = 'h100; v <= 'h108; v++) pte_tab[20'(v)] = {20'(v + 'h200), 12'h003};

      repeat (3) @(posedge clk);
      #1;
      check("rst_outputs",
            {22'h0, cpu_req_ready, cpu_resp_valid, cpu_page_fault, pt_req,
             cc_read_mem, cc_write_mem, |cpu_rdata, |pt_addr, |cc_phy_addr, |cc_data_out}, 0);
      rst_n = 1;
      @(posedge clk); #1;

      // Cold load walks; hand-computed values pin the model.
      run_req(0, 32'h0000_5123, 32'h0, 0);
      check("lit_pt_addr", last_pt_addr, 32'h0010_0014);
      check("lit_pa", last_pa, 32'h0003_7123);
      check("lit_rdata", last_rdata, 32'hDEAE_7123);
      run_req(0, 32'h0000_5123, 32'h0, 0);
      check("lit_hit_no_walk", n_pt_req, 0);
      run_req(1, 32'h0000_5FFC, 32'h1234_5678, 0);
      run_req(0, 32'h0000_5FFC, 32'h0, 0);
      check("lit_store_load", last_rdata, 32'h1234_5678);

      // Read-only page: store faults but the entry stays cached.
      run_req(1, 32'h0004_2010, 32'hCAFE_F00D, 0);
      check("lit_ro_fault", 32'(last_fault), 1);
      run_req(0, 32'h0004_2010, 32'h0, 0);
      check("lit_ro_hit", n_pt_req, 0);

      // Invalid PTE: fault, no fill, so the retry walks again.
      run_req(0, 32'h0007_7000, 32'h0, 0);
      run_req(0, 32'h0007_7000, 32'h0, 0);
      check("lit_invalid_rewalk", n_pt_req, 1);

      // Nine distinct pages: 0x100 is evicted, 0x101 survives.
      for (int v = 'h100; v <= 'h108; v++) run_req(0, {20'(v), 12'h0AB}, 32'h0, 0);
      run_req(0, 32'h0010_10AB, 32'h0, 0);
      check("lit_second_hits", n_pt_req, 0);
      run_req(0, 32'h0010_00AB, 32'h0, 0);
      check("lit_first_rewalk", n_pt_req, 1);

      // Flush in the pt_ready cycle: request completes, fill is dropped.
      run_req(0, 32'h0000_9000, 32'h0, 1);
      check("lit_flush_pa", last_pa, 32'h0009_9000);
      run_req(0, 32'h0000_9000, 32'h0, 0);
      check("lit_flush_rewalk", n_pt_req, 1);
      run_req(0, 32'h0010_10AB, 32'h0, 0);
      check("lit_flush_cleared", n_pt_req, 1);

      // PTE address wraps modulo 2^32.
      ptbr = 32'hFFF0_0000;
      run_req(0, 32'hFFFF_F008, 32'h0, 0);
      check("lit_pt_wrap", last_pt_addr, 32'h002F_FFFC);
      check("lit_wrap_pa", last_pa, 32'h0000_1008);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
